// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, PS/2 mouse command/response bytes and stream header layout
package ps2_pkg;
  typedef enum logic [3:0] {
    SEND_RST, WAIT_ACK1, WAIT_BAT, WAIT_ID, SEND_EN, WAIT_ACK2, B0, B1, B2, FAIL
  } ps2_state_e;
  typedef struct packed {
    logic       y_ovf;
    logic       x_ovf;
    logic       y_sign;
    logic       x_sign;
    logic [2:0] btn;
  } ps2_hdr_t;
  localparam logic [7:0] PS2_CMD_RESET     = 8'hFF;
  localparam logic [7:0] PS2_CMD_STREAM_EN = 8'hF4;
  localparam logic [7:0] PS2_ACK           = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK        = 8'hAA;
  localparam logic [7:0] PS2_MOUSE_ID      = 8'h00;
  function automatic logic [7:0] ps2_expect(input ps2_state_e s);
    return s == WAIT_BAT ? PS2_BAT_OK : s == WAIT_ID ? PS2_MOUSE_ID : PS2_ACK;
  endfunction
endpackage

// File: rtl/ps2_cursor_clamp.sv
// ps2_cursor_clamp: one cursor axis, adds or subtracts a signed 9-bit delta and clamps to 0..MAXV
module ps2_cursor_clamp #(
  parameter int PW   = 10,
  parameter int MAXV = 639,
  parameter int INIT = 320,
  parameter bit SUB  = 1'b0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en_i,
  input  logic [8:0]    delta_i,
  output logic [PW-1:0] pos_o
);
  logic signed [10:0] cur, dlt, sum;
  logic [PW-1:0] pos_d;
  // widen to 11-bit signed so the sum cannot wrap before clamping
  always_comb begin
    cur = $signed(11'(pos_o));
    dlt = $signed({{2{delta_i[8]}}, delta_i});
    sum = SUB ? cur - dlt : cur + dlt;
    pos_d = !en_i ? pos_o : sum < 0 ? '0 : sum > $signed(11'(MAXV)) ? PW'(MAXV) : sum[PW-1:0];
  end
  // position register, starts at screen centre
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) pos_o <= PW'(INIT);
    else pos_o <= pos_d;
endmodule

// File: rtl/ps2_mouse_ctrl.sv
// ps2_mouse_ctrl: PS/2 mouse init handshake, packet decode and clamped cursor; PS2_MOUSE_RETRY_EN allows 3 init attempts
module ps2_mouse_ctrl
  import ps2_pkg::*;
#(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int RESP_TIMEOUT = 60_000_000,
  parameter int PKT_GAP      = 200_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  input  logic       tx_busy,
  input  logic       tx_complete,
  output logic [7:0] tx_data,
  output logic       tx_enable,
  output logic       init_done,
  output logic       init_fail,
  output logic [2:0] buttons,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic [9:0] pos_x,
  output logic [8:0] pos_y,
  output logic       pkt_valid
);
  localparam int TMAX = RESP_TIMEOUT > PKT_GAP ? RESP_TIMEOUT : PKT_GAP;
  localparam int CW = $clog2(TMAX + 1);
  ps2_state_e state_q, state_d, fail_st;
  ps2_hdr_t b0_q, b0_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] tx_data_q, tx_data_d, x_q, x_d;
  logic [8:0] dx_q, dx_d, dy_q, dy_d, dx_n, dy_n;
  logic [2:0] btn_q, btn_d;
  logic rx_q, txc_q, seen_q, seen_d, tx_en_q, tx_en_d, pkt_q;
  logic rx_ev, tx_done, snd, tmo, gap, fail, pkt;
  assign rx_ev   = rx_valid & ~rx_q;
  assign snd     = state_q == SEND_RST || state_q == SEND_EN;
  assign tx_done = tx_complete & ~txc_q & seen_q;
  assign tmo     = cnt_q == CW'(RESP_TIMEOUT);
  assign gap     = cnt_q == CW'(PKT_GAP);
`ifdef PS2_MOUSE_RETRY_EN
  logic [1:0] tries_q;
  // failed init attempts so far; the third one is terminal
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) tries_q <= '0;
    else if (fail) tries_q <= tries_q + 2'd1;
  assign fail_st = tries_q == 2'd2 ? FAIL : SEND_RST;
`else
  assign fail_st = FAIL;
`endif
  // state register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state_q <= SEND_RST;
    else state_q <= state_d;
  // next state: init handshake, then stream byte tracking; a byte beats a same-cycle timeout
  always_comb begin
    state_d = state_q;
    fail = 1'b0;
    case (state_q)
      SEND_RST: state_d = tx_done ? WAIT_ACK1 : state_q;
      SEND_EN:  state_d = tx_done ? WAIT_ACK2 : state_q;
      WAIT_ACK1, WAIT_BAT, WAIT_ID, WAIT_ACK2: begin
        fail = rx_ev ? (rx_error | (rx_data != ps2_expect(state_q))) : tmo;
        state_d = fail ? fail_st : !rx_ev ? state_q :
                  state_q == WAIT_ACK1 ? WAIT_BAT : state_q == WAIT_BAT ? WAIT_ID :
                  state_q == WAIT_ID ? SEND_EN : B0;
      end
      B0: state_d = rx_ev && !rx_error && rx_data[3] ? B1 : B0;
      B1: state_d = rx_ev ? (rx_error ? B0 : B2) : gap ? B0 : B1;
      B2: state_d = rx_ev || gap ? B0 : B2;
      default: state_d = state_q;
    endcase
  end
  // outputs and datapath next values; counters and busy-seen flag restart on every state change
  always_comb begin
    pkt = state_q == B2 && rx_ev && !rx_error;
    cnt_d = state_d != state_q ? '0 : cnt_q + CW'(cnt_q != CW'(TMAX));
    seen_d = state_d != state_q ? 1'b0 : seen_q | (snd & tx_busy);
    tx_en_d = snd & ~seen_q & ~tx_busy;
    tx_data_d = state_q == SEND_RST ? PS2_CMD_RESET : state_q == SEND_EN ? PS2_CMD_STREAM_EN : tx_data_q;
    b0_d = state_q == B0 && state_d == B1 ? {rx_data[7:4], rx_data[2:0]} : b0_q;
    x_d = state_q == B1 && state_d == B2 ? rx_data : x_q;
    dx_n = b0_q.x_ovf ? '0 : {b0_q.x_sign, x_q};
    dy_n = b0_q.y_ovf ? '0 : {b0_q.y_sign, rx_data};
    dx_d = pkt ? dx_n : dx_q;
    dy_d = pkt ? dy_n : dy_q;
    btn_d = pkt ? b0_q.btn : btn_q;
  end
  // edge detectors, handshake and packet registers
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rx_q <= 1'b0;
      txc_q <= 1'b0;
      cnt_q <= '0;
      seen_q <= 1'b0;
      tx_en_q <= 1'b0;
      tx_data_q <= '0;
      b0_q <= '0;
      x_q <= '0;
      dx_q <= '0;
      dy_q <= '0;
      btn_q <= '0;
      pkt_q <= 1'b0;
    end else begin
      rx_q <= rx_valid;
      txc_q <= tx_complete;
      cnt_q <= cnt_d;
      seen_q <= seen_d;
      tx_en_q <= tx_en_d;
      tx_data_q <= tx_data_d;
      b0_q <= b0_d;
      x_q <= x_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      btn_q <= btn_d;
      pkt_q <= pkt;
    end
  ps2_cursor_clamp #(.PW(10), .MAXV(SCREEN_W - 1), .INIT(SCREEN_W / 2), .SUB(1'b0)) u_x (
    .clk(clk), .rstn(rstn), .en_i(pkt), .delta_i(dx_n), .pos_o(pos_x)
  );
  ps2_cursor_clamp #(.PW(9), .MAXV(SCREEN_H - 1), .INIT(SCREEN_H / 2), .SUB(1'b1)) u_y (
    .clk(clk), .rstn(rstn), .en_i(pkt), .delta_i(dy_n), .pos_o(pos_y)
  );
  assign tx_data   = tx_data_q;
  assign tx_enable = tx_en_q;
  assign init_done = state_q == B0 || state_q == B1 || state_q == B2;
  assign init_fail = state_q == FAIL;
  assign buttons   = btn_q;
  assign dx        = dx_q;
  assign dy        = dy_q;
  assign pkt_valid = pkt_q;
endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// tb_ps2_mouse_ctrl: transmitter/mouse models plus an arithmetic cursor model for ps2_mouse_ctrl
module tb_ps2_mouse_ctrl;
  localparam int RT = 2000, PG = 100, W = 640, H = 480;
`ifdef PS2_MOUSE_RETRY_EN
  localparam int TRIES = 3;
`else
  localparam int TRIES = 1;
`endif
  logic clk = 1'b0, rstn = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0, rx_error = 1'b0, tx_busy = 1'b0, tx_complete = 1'b0;
  logic [7:0] tx_data;
  logic tx_enable, init_done, init_fail, pkt_valid;
  logic [2:0] buttons;
  logic [8:0] dx, dy, pos_y;
  logic [9:0] pos_x;
  int checks = 0, passed = 0, pkt_cnt = 0, tx_rise = 0;
  int mx, my;
  logic tx_prev = 1'b0;

  ps2_mouse_ctrl #(.SCREEN_W(W), .SCREEN_H(H), .RESP_TIMEOUT(RT), .PKT_GAP(PG)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
    .tx_busy(tx_busy), .tx_complete(tx_complete), .tx_data(tx_data), .tx_enable(tx_enable),
    .init_done(init_done), .init_fail(init_fail), .buttons(buttons), .dx(dx), .dy(dy),
    .pos_x(pos_x), .pos_y(pos_y), .pkt_valid(pkt_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pkt_valid) pkt_cnt++;
    if (tx_enable && !tx_prev) tx_rise++;
    tx_prev = tx_enable;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int clampi(input int v, input int hi);
    return v < 0 ? 0 : v > hi ? hi : v;
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_enable", tx_enable, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_init_done", init_done, 0);
    check("rst_init_fail", init_fail, 0);
    check("rst_buttons", buttons, 0);
    check("rst_dx", dx, 0);
    check("rst_dy", dy, 0);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_pos_x", pos_x, W / 2);
    check("rst_pos_y", pos_y, H / 2);
    rstn = 1'b1;
    mx = W / 2;
    my = H / 2;
  endtask

  task automatic wait_tx(output logic [7:0] b);
    int n = 0;
    b = '0;
    while (!tx_enable && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_enable) begin
      check("tx_enable_timeout", 0, 1);
      return;
    end
    b = tx_data;
    repeat (2) @(negedge clk);
    tx_busy = 1'b1;
    n = 0;
    while (tx_enable && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("tx_enable_drop", tx_enable, 0);
    repeat (20) @(negedge clk);
    tx_busy = 1'b0;
    tx_complete = 1'b1;
    repeat (2) @(negedge clk);
    tx_complete = 1'b0;
    @(negedge clk);
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic e);
    @(negedge clk);
    rx_data = b;
    rx_error = e;
    rx_valid = 1'b1;
    repeat (2) @(negedge clk);
    rx_valid = 1'b0;
    rx_error = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic apply(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int c = pkt_cnt;
    int dxi, dyi;
    rx_byte(b0, 1'b0);
    rx_byte(b1, 1'b0);
    rx_byte(b2, 1'b0);
    dxi = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
    dyi = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
    mx = clampi(mx + dxi, W - 1);
    my = clampi(my - dyi, H - 1);
    check("pkt_count", pkt_cnt - c, 1);
    check("dx", dx, dxi[8:0]);
    check("dy", dy, dyi[8:0]);
    check("buttons", buttons, b0[2:0]);
    check("pos_x", pos_x, mx);
    check("pos_y", pos_y, my);
  endtask

  initial begin
    logic [7:0] b;
    int c;
    do_reset();
    for (int a = 0; a < TRIES; a++) begin
      wait_tx(b);
      check("fc_cmd", b, 8'hFF);
      check("fc_fail_early", init_fail, 0);
      rx_byte(8'hFA, 1'b0);
      rx_byte(8'hFC, 1'b0);
    end
    repeat (2) @(negedge clk);
    check("fc_init_fail", init_fail, 1);
    check("fc_init_done", init_done, 0);
    c = tx_rise;
    repeat (300) @(negedge clk);
    check("fc_no_tx", tx_rise, c);

    do_reset();
    for (int a = 0; a < TRIES; a++) begin
      wait_tx(b);
      check("to_cmd", b, 8'hFF);
      repeat (RT - 30) @(negedge clk);
      check("to_fail_early", init_fail, 0);
      repeat (50) @(negedge clk);
    end
    check("to_init_fail", init_fail, 1);

    do_reset();
    wait_tx(b);
    check("init_cmd_reset", b, 8'hFF);
    rx_byte(8'hFA, 1'b0);
    rx_byte(8'hAA, 1'b0);
    rx_byte(8'h00, 1'b0);
    check("init_done_early", init_done, 0);
    wait_tx(b);
    check("init_cmd_stream", b, 8'hF4);
    rx_byte(8'hFA, 1'b0);
    check("init_done", init_done, 1);
    check("init_fail", init_fail, 0);

    apply(8'h28, 8'h05, 8'hFB);
    check("dir_pos_x", pos_x, 325);
    check("dir_pos_y", pos_y, 245);
    c = pkt_cnt;
    rx_byte(8'h00, 1'b0);
    check("discard_byte0", pkt_cnt - c, 0);
    apply(8'h18, 8'h00, 8'h00);
    apply(8'h18, 8'hBE, 8'h00);
    check("pos_x_at_3", pos_x, 3);
    apply(8'h18, 8'hF0, 8'h00);
    check("pos_x_clamp0", pos_x, 0);

    c = pkt_cnt;
    rx_byte(8'h08, 1'b0);
    repeat (PG + 10) @(negedge clk);
    apply(8'h09, 8'h01, 8'h01);
    check("gap_one_pkt", pkt_cnt - c, 1);
    check("gap_buttons", buttons, 3'b001);

    for (int i = 0; i < 40; i++) begin
      int r = $urandom_range(0, 5);
      c = pkt_cnt;
      b = 8'($urandom);
      if (r == 0) begin
        b[3] = 1'b0;
        rx_byte(b, 1'b0);
        check("rnd_discard", pkt_cnt - c, 0);
      end else if (r == 1) begin
        b[3] = 1'b1;
        rx_byte(b, 1'b1);
        check("rnd_err_b0", pkt_cnt - c, 0);
      end else if (r == 2) begin
        b[3] = 1'b1;
        rx_byte(b, 1'b0);
        rx_byte(8'($urandom), 1'b1);
        check("rnd_err_b1", pkt_cnt - c, 0);
      end else begin
        b[3] = 1'b1;
        apply(b, 8'($urandom), 8'($urandom));
      end
    end

    rx_byte(8'h08, 1'b0);
    do_reset();
    wait_tx(b);
    check("mid_rst_cmd", b, 8'hFF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
